// File: rtl/score_sched_pkg.sv
// Shared types and default constants for the score event scheduler.
package score_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  localparam int NUM_SRC_DEF = 4;
  localparam int PEND_W_DEF  = 3;
  localparam int MIN_GAP_DEF = 1;
  localparam int DROP_MAX    = 255;

endpackage

// File: rtl/score_event_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IDX_W'((int'(ptr_i) + k) % N);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/score_event_scheduler.sv
// Queues hit events per source and issues round-robin score-increment pulses
// while the update window is open and the score is not saturated.
module score_event_scheduler
  import score_sched_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int PEND_W  = PEND_W_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_SRC-1:0] hit_req_i,
  input  logic               update_window_i,
  input  logic               score_full_i,
  input  logic               clear_pending_i,
  output logic               update_score_o,
  output logic [NUM_SRC-1:0] grant_o,
  output logic               pending_any_o,
  output logic               overflow_o,
  output logic [7:0]         dropped_count_o
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0]  pend_q [NUM_SRC];
  logic [PEND_W-1:0]  pend_d [NUM_SRC];
  state_e             state_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [IDX_W-1:0]   gidx_q, rr_q;
  logic [GAP_W-1:0]   gap_q;
  logic               pany_q, ovf_q;
  logic [7:0]         drop_q, drop_d;

  logic [NUM_SRC-1:0] req, dec, sat_hit, arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               commit, any_nz_d;
  int                 drop_sum;

  // Reset gates the pulse so a reset landing in ISSUE never increments the score.
  assign commit = (state_q == ISSUE) & resetn & update_window_i
                & ~score_full_i & ~clear_pending_i;
  assign dec    = grant_q & {NUM_SRC{commit}};

  rr_arbiter #(.N(NUM_SRC), .IDX_W(IDX_W)) u_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    sat_hit  = '0;
    req      = '0;
    any_nz_d = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_d[i] = pend_q[i];
      req[i]    = (pend_q[i] != '0);
      if (clear_pending_i) begin
        pend_d[i] = '0;
      end else if (hit_req_i[i] && !dec[i]) begin
        if (pend_q[i] == PEND_MAX) sat_hit[i] = 1'b1;
        else                       pend_d[i] = pend_q[i] + 1'b1;
      end else if (!hit_req_i[i] && dec[i]) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end
      any_nz_d = any_nz_d | (pend_d[i] != '0);
    end
    drop_sum = int'(drop_q) + $countones(sat_hit);
    drop_d   = (drop_sum > DROP_MAX) ? 8'(DROP_MAX) : 8'(drop_sum);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SRC; i++) pend_q[i] <= '0;
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      pany_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      pend_q <= pend_d;
      pany_q <= any_nz_d;
      drop_q <= drop_d;
      if (|sat_hit) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (update_window_i && pany_q && !score_full_i && !clear_pending_i) begin
            state_q <= ISSUE;
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
          end
        end
        ISSUE: begin
          grant_q <= '0;
          if (commit) begin
            rr_q <= (gidx_q == IDX_W'(NUM_SRC - 1)) ? '0 : gidx_q + 1'b1;
            if (MIN_GAP > 0) begin
              state_q <= COOLDOWN;
              gap_q   <= GAP_W'(MIN_GAP - 1);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        COOLDOWN: begin
          if (clear_pending_i || gap_q == '0) state_q <= IDLE;
          else                                gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign update_score_o  = commit;
  assign grant_o         = grant_q;
  assign pending_any_o   = pany_q;
  assign overflow_o      = ovf_q;
  assign dropped_count_o = drop_q;

endmodule

// File: tb/tb_score_event_scheduler.sv
// Directed bench for score_event_scheduler: vector table plus hand-written corner sequences.
module tb_score_event_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] hit_req;
  logic         update_window, score_full, clear_pending;
  logic         update_score;
  logic [N-1:0] grant;
  logic         pending_any, overflow;
  logic [7:0]   dropped_count;

  int total = 0;
  int bad   = 0;
  int score = 0;
  logic [N-1:0] gnt_log[$];

  typedef struct {
    bit       rst;
    bit [3:0] hit;
    bit       win;
    bit       full;
    bit       clr;
    bit       e_upd;
    bit [3:0] e_gnt;
    bit       e_pany;
  } vec_t;

  vec_t vt[$];

  score_event_scheduler #(.NUM_SRC(N), .PEND_W(3), .MIN_GAP(1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .hit_req_i       (hit_req),
    .update_window_i (update_window),
    .score_full_i    (score_full),
    .clear_pending_i (clear_pending),
    .update_score_o  (update_score),
    .grant_o         (grant),
    .pending_any_o   (pending_any),
    .overflow_o      (overflow),
    .dropped_count_o (dropped_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream score counter.
  always @(posedge clk) if (update_score) score <= score + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit [3:0] h, input bit w, input bit f, input bit c);
    hit_req       = h;
    update_window = w;
    score_full    = f;
    clear_pending = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    hit_req = '0; update_window = 1'b0; score_full = 1'b0; clear_pending = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic count_pulses(input int ncyc, input bit w, input bit f, output int np);
    gnt_log.delete();
    np = 0;
    repeat (ncyc) begin
      drive(4'b0000, w, f, 1'b0);
      if (update_score) begin
        np++;
        gnt_log.push_back(grant);
      end
      tick();
    end
  endtask

  task automatic add(input bit rst, input bit [3:0] h, input bit w,
                     input bit u, input bit [3:0] g, input bit p);
    vt.push_back('{rst: rst, hit: h, win: w, full: 1'b0, clr: 1'b0,
                   e_upd: u, e_gnt: g, e_pany: p});
  endtask

  initial begin
    int np, s0;

    do_reset();
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("reset.upd",   int'(update_score),  0);
    chk("reset.grant", int'(grant),         0);
    chk("reset.pany",  int'(pending_any),   0);
    chk("reset.ovf",   int'(overflow),      0);
    chk("reset.drop",  int'(dropped_count), 0);

    // single hit on source 0
    add(1, 4'b0001, 1, 0, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 1, 4'b0001, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0);
    // all four sources at once: grants in order, two idle cycles between pulses
    add(1, 4'b1111, 1, 0, 4'b0000, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 1, 4'b0001, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 1, 4'b0010, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 1, 4'b0100, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 1);
    add(0, 4'b0000, 1, 1, 4'b1000, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0);

    s0 = score;
    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      drive(vt[i].hit, vt[i].win, vt[i].full, vt[i].clr);
      chk($sformatf("vec%0d.upd", i),   int'(update_score), int'(vt[i].e_upd));
      chk($sformatf("vec%0d.grant", i), int'(grant),        int'(vt[i].e_gnt));
      chk($sformatf("vec%0d.pany", i),  int'(pending_any),  int'(vt[i].e_pany));
      chk($sformatf("vec%0d.ovf", i),   int'(overflow),     0);
      tick();
    end
    chk("table.score", score - s0, 5);

    // window closes during ISSUE: no pulse, event kept and retried
    do_reset();
    drive(4'b0100, 1, 0, 0); tick();
    drive(4'b0000, 1, 0, 0); tick();
    drive(4'b0000, 0, 0, 0);
    chk("wdrop.upd",   int'(update_score), 0);
    chk("wdrop.grant", int'(grant), 4);
    tick();
    drive(4'b0000, 0, 0, 0);
    chk("wdrop.kept",  int'(pending_any), 1);
    chk("wdrop.gidle", int'(grant), 0);
    tick();
    drive(4'b0000, 0, 0, 0); tick();
    drive(4'b0000, 1, 0, 0);
    chk("wdrop.reopen_upd", int'(update_score), 0);
    tick();
    drive(4'b0000, 1, 0, 0);
    chk("wdrop.retry_upd",   int'(update_score), 1);
    chk("wdrop.retry_grant", int'(grant), 4);
    tick();
    drive(4'b0000, 1, 0, 0);
    chk("wdrop.empty", int'(pending_any), 0);
    tick();

    // saturation on source 2
    do_reset();
    repeat (9) begin drive(4'b0100, 0, 0, 0); tick(); end
    drive(4'b0000, 0, 0, 0);
    chk("sat.pany", int'(pending_any), 1);
    chk("sat.ovf",  int'(overflow), 1);
    chk("sat.drop", int'(dropped_count), 2);
    s0 = score;
    count_pulses(40, 1, 0, np);
    chk("sat.pulses", np, 7);
    chk("sat.score",  score - s0, 7);
    foreach (gnt_log[i]) chk($sformatf("sat.grant%0d", i), int'(gnt_log[i]), 4);
    drive(4'b0000, 0, 0, 0);
    chk("sat.drained", int'(pending_any), 0);
    repeat (270) begin drive(4'b0100, 0, 0, 0); tick(); end
    drive(4'b0000, 0, 0, 1); tick();
    drive(4'b0000, 0, 0, 0);
    chk("sat.drop_max", int'(dropped_count), 255);
    chk("sat.ovf_kept", int'(overflow), 1);
    chk("sat.cleared",  int'(pending_any), 0);

    // clear_pending in the ISSUE cycle together with new hits
    do_reset();
    drive(4'b0111, 1, 0, 0); tick();
    drive(4'b0000, 1, 0, 0); tick();
    drive(4'b0011, 1, 0, 1);
    chk("clr.issue_grant", int'(grant), 1);
    chk("clr.upd",         int'(update_score), 0);
    tick();
    drive(4'b0000, 1, 0, 0);
    chk("clr.pany",  int'(pending_any), 0);
    chk("clr.grant", int'(grant), 0);
    count_pulses(10, 1, 0, np);
    chk("clr.pulses", np, 0);
    chk("clr.ovf",    int'(overflow), 0);

    // score_full blocks issue, then three pulses in round-robin order
    do_reset();
    drive(4'b0111, 0, 0, 0); tick();
    count_pulses(10, 1, 1, np);
    chk("full.pulses", np, 0);
    drive(4'b0000, 1, 1, 0);
    chk("full.held", int'(pending_any), 1);
    count_pulses(20, 1, 0, np);
    chk("full.release_pulses", np, 3);
    if (gnt_log.size() == 3) begin
      chk("full.g0", int'(gnt_log[0]), 1);
      chk("full.g1", int'(gnt_log[1]), 2);
      chk("full.g2", int'(gnt_log[2]), 4);
    end
    drive(4'b0000, 1, 0, 0);
    chk("full.empty", int'(pending_any), 0);

    // reset while in ISSUE: no pulse, queue lost
    do_reset();
    drive(4'b0001, 1, 0, 0); tick();
    drive(4'b0000, 1, 0, 0); tick();
    resetn = 1'b0;
    drive(4'b0000, 1, 0, 0);
    chk("rstiss.upd", int'(update_score), 0);
    tick();
    resetn = 1'b1;
    drive(4'b0000, 1, 0, 0);
    chk("rstiss.pany",  int'(pending_any), 0);
    chk("rstiss.grant", int'(grant), 0);
    count_pulses(10, 1, 0, np);
    chk("rstiss.pulses", np, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
